// File: rtl/prog_loader_if.sv
// Host byte channel and instruction-memory write port used by prog_loader.
// master = loader side, slave = host bridge / memory side.
interface prog_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;

   modport master (
      input  rx_valid, rx_data, mem_ack,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_valid, rx_data, mem_ack,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Streams a little-endian program image (base, count, words) into instruction memory,
// holding the core in reset meanwhile. Define LOADER_CSUM_EN for a trailing 32-bit checksum.
module prog_loader #(
   parameter logic [31:0] ADDR_LO   = 32'h8000_0000,
   parameter int unsigned MEM_WORDS = 4096
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   prog_loader_if.master bus,
   output logic         core_reset_n,
   output logic         busy,
   output logic         done,
   output logic         error
);

   typedef enum logic [2:0] {
      IDLE, HDR_ADDR, HDR_LEN, DATA, WRITE,
`ifdef LOADER_CSUM_EN
      CSUM,
`endif
      DONE, ERROR
   } state_t;

`ifdef LOADER_CSUM_EN
   localparam state_t AFTER_DATA = CSUM;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   state_t      state, state_nx;
   logic [1:0]  byte_cnt;
   logic [31:0] word_buf;
   logic [31:0] base;
   logic [31:0] remaining;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        rx_open;
   logic        fire;
   logic        last_byte;
   logic        start_ok;
   logic [31:0] word_full;
   logic [31:0] offs;
   logic [32:0] end_word;
   logic        range_ok;
`ifdef LOADER_CSUM_EN
   logic [31:0] csum;
`endif

`ifdef LOADER_CSUM_EN
   assign rx_open = (state == HDR_ADDR) || (state == HDR_LEN) || (state == DATA) || (state == CSUM);
`else
   assign rx_open = (state == HDR_ADDR) || (state == HDR_LEN) || (state == DATA);
`endif

   assign bus.rx_ready  = rx_open;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign fire          = bus.rx_valid && rx_open;
   assign last_byte     = fire && (byte_cnt == 2'd3);
   assign start_ok      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

   // Bytes shift in from the top, so the 4th byte completes a little-endian word.
   assign word_full = {bus.rx_data, word_buf[31:8]};

   // Range check in 33 bits so a huge count cannot wrap past the memory end.
   assign offs     = (base - ADDR_LO) >> 2;
   assign end_word = {1'b0, offs} + {1'b0, word_full};
   assign range_ok = (base[1:0] == 2'b00) && (base >= ADDR_LO) && (end_word <= 33'(MEM_WORDS));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         core_reset_n <= 1'b0;
      end else begin
         state        <= state_nx;
         core_reset_n <= (state_nx == IDLE) || (state_nx == DONE);
      end
   end

   always_comb begin
      state_nx    = state;
      bus.mem_we  = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = HDR_ADDR;
         end
         HDR_ADDR: if (last_byte) state_nx = HDR_LEN;
         HDR_LEN: begin
            if (last_byte) begin
               if (!range_ok)              state_nx = ERROR;
               else if (word_full == 32'd0) state_nx = AFTER_DATA;
               else                        state_nx = DATA;
            end
         end
         DATA: if (last_byte) state_nx = WRITE;
         WRITE: begin
            bus.mem_we = 1'b1;
            if (bus.mem_ack) state_nx = (remaining == 32'd1) ? AFTER_DATA : DATA;
         end
`ifdef LOADER_CSUM_EN
         CSUM: if (last_byte) state_nx = (word_full == csum) ? DONE : ERROR;
`endif
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_nx = HDR_ADDR;
         end
         ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
            if (start) state_nx = HDR_ADDR;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt  <= 2'd0;
         word_buf  <= 32'd0;
         base      <= 32'd0;
         remaining <= 32'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
`ifdef LOADER_CSUM_EN
         csum      <= 32'd0;
`endif
      end else if (start_ok) begin
         byte_cnt  <= 2'd0;
`ifdef LOADER_CSUM_EN
         csum      <= 32'd0;
`endif
      end else begin
         if (fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= word_full;
         end
         if (last_byte) begin
            case (state)
               HDR_ADDR: base <= word_full;
               HDR_LEN: begin
                  remaining <= word_full;
                  if (range_ok && (word_full != 32'd0)) addr_q <= base;
               end
               DATA:    wdata_q <= word_full;
               default: ;
            endcase
         end
         if ((state == WRITE) && bus.mem_ack) begin
            addr_q    <= addr_q + 32'd4;
            remaining <= remaining - 32'd1;
`ifdef LOADER_CSUM_EN
            csum      <= csum + wdata_q;
`endif
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven load sessions with a write scoreboard,
// plus hand sequences for ack stalls and mid-session reset.
module tb_prog_loader;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic core_reset_n, busy, done, error;

   prog_loader_if bus ();

   prog_loader #(.ADDR_LO(32'h8000_0000), .MEM_WORDS(4096)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .bus          (bus),
      .core_reset_n (core_reset_n),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]       addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct packed {
      logic [31:0]       base;
      logic [31:0]       n;
      logic [2:0][31:0]  d;
      logic              err;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[9];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: every accepted write is popped and compared.
   always @(negedge clk) begin
      if (reset_n && bus.mem_we && bus.mem_ack) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", bus.mem_addr, 32'hxxxx_xxxx);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_addr", bus.mem_addr, e.addr);
            chk("write_data", bus.mem_wdata, e.data);
         end
      end
   end

   task automatic set_vec(input int i, input logic [31:0] b, input logic [31:0] n,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic err);
      vecs[i].base = b;
      vecs[i].n    = n;
      vecs[i].d    = {d2, d1, d0};
      vecs[i].err  = err;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  t;
      logic acc;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      t = 0;
      forever begin
         @(negedge clk);
         acc = bus.rx_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         t++;
         if (t > 100) begin
            chk("rx_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic start_pulse();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_done_clr", {31'd0, done}, 32'd0);
      chk("start_err_clr", {31'd0, error}, 32'd0);
      chk("start_core_rst", {31'd0, core_reset_n}, 32'd0);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while (busy === 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] sum;
      sum = 32'd0;
      start_pulse();
      send_word(v.base);
      send_word(v.n);
      if (!v.err) begin
         for (int i = 0; i < int'(v.n); i++) begin
            exp_q.push_back('{addr: v.base + 32'(4 * i), data: v.d[i]});
            sum = sum + v.d[i];
            send_word(v.d[i]);
         end
`ifdef LOADER_CSUM_EN
         send_word(sum);
`endif
      end
      wait_idle();
      chk({tag, "_done"}, {31'd0, done}, {31'd0, !v.err});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, v.err});
      chk({tag, "_core_rst"}, {31'd0, core_reset_n}, {31'd0, !v.err});
      chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
      chk({tag, "_core_rst"}, {31'd0, core_reset_n}, 32'd0);
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.mem_ack  = 1'b1;

      set_vec(0, 32'h8000_0000, 32'd2, 32'h0000_0013, 32'h0000_006F, 32'd0, 1'b0);
      set_vec(1, 32'h8000_0002, 32'd2, 32'd0, 32'd0, 32'd0, 1'b1);
      set_vec(2, 32'h8000_3FFC, 32'd2, 32'd0, 32'd0, 32'd0, 1'b1);
      set_vec(3, 32'h8000_3FFC, 32'd1, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
      set_vec(4, 32'h7FFF_FFFC, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1);
      set_vec(5, 32'h8000_0100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      set_vec(6, 32'h8000_0010, 32'd3, 32'h1122_3344, 32'hCAFE_F00D, 32'h0000_0001, 1'b0);
      set_vec(7, 32'h8000_3FF4, 32'd3, 32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 1'b0);
      set_vec(8, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      chk("core_rst_before_edge", {31'd0, core_reset_n}, 32'd0);
      @(posedge clk); #1;
      chk("core_rst_after_edge", {31'd0, core_reset_n}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_error", {31'd0, error}, 32'd0);
      chk("idle_mem_we", {31'd0, bus.mem_we}, 32'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef LOADER_CSUM_EN
      // Bad checksum must end in ERROR after both words are written.
      start_pulse();
      send_word(32'h8000_0000);
      send_word(32'd2);
      exp_q.push_back('{addr: 32'h8000_0000, data: 32'h0000_0013});
      send_word(32'h0000_0013);
      exp_q.push_back('{addr: 32'h8000_0004, data: 32'h0000_006F});
      send_word(32'h0000_006F);
      send_word(32'h0000_0000);
      wait_idle();
      chk("badcsum_error", {31'd0, error}, 32'd1);
      chk("badcsum_done", {31'd0, done}, 32'd0);
      chk("badcsum_core_rst", {31'd0, core_reset_n}, 32'd0);
`endif

      // Ack stall: write held for four cycles, pending byte kept on the channel.
      start_pulse();
      send_word(32'h8000_0040);
      send_word(32'd2);
      exp_q.push_back('{addr: 32'h8000_0040, data: 32'hA5A5_0001});
      bus.mem_ack = 1'b0;
      send_word(32'hA5A5_0001);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h78;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_we", i), {31'd0, bus.mem_we}, 32'd1);
         chk($sformatf("stall%0d_addr", i), bus.mem_addr, 32'h8000_0040);
         chk($sformatf("stall%0d_wdata", i), bus.mem_wdata, 32'hA5A5_0001);
         chk($sformatf("stall%0d_rx_ready", i), {31'd0, bus.rx_ready}, 32'd0);
         @(posedge clk); #1;
         if (i == 2) bus.mem_ack = 1'b1;
      end
      exp_q.push_back('{addr: 32'h8000_0044, data: 32'h1234_5678});
      send_word(32'h1234_5678);
`ifdef LOADER_CSUM_EN
      send_word(32'hA5A5_0001 + 32'h1234_5678);
`endif
      wait_idle();
      chk("stall_done", {31'd0, done}, 32'd1);
      chk("stall_pending", exp_q.size(), 32'd0);

      // Reset in the middle of a session, then a clean reload.
      start_pulse();
      send_word(32'h8000_0000);
      send_word(32'd3);
      exp_q.push_back('{addr: 32'h8000_0000, data: 32'hAAAA_5555});
      send_word(32'hAAAA_5555);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_first_written", exp_q.size(), 32'd0);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_core_rst_idle", {31'd0, core_reset_n}, 32'd1);
      run_vec(vecs[6], "reload");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
